// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment display path (scanner and decoder).
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0]            nibble_t;
    typedef logic [2:0]            digit_sel_t;
    typedef logic [31:0]           disp_word_t;
    typedef logic [NUM_DIGITS-1:0] digit_mask_t;

    localparam digit_sel_t LAST_DIGIT = digit_sel_t'(NUM_DIGITS - 1);

    function automatic nibble_t digit_of(input disp_word_t word, input digit_sel_t idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seven_seg_scanner_prescaler.sv
// Terminal-count divider: tick is high for one cycle out of every DIV.
module refresh_prescaler #(
    parameter int DIV   = 100000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit scan controller with a double-buffered value/mask that is
// swapped in only at frame boundaries.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_mask,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        pending,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic        tick;
    digit_sel_t  sel_reg;
    disp_word_t  disp_reg;
    digit_mask_t en_reg;
    disp_word_t  shadow_data;
    digit_mask_t shadow_mask;
    logic        pending_reg;
    logic        frame_start_reg;

    refresh_prescaler #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg         <= '0;
            disp_reg        <= '0;
            en_reg          <= '0;
            shadow_data     <= '0;
            shadow_mask     <= '0;
            pending_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (tick) begin
                sel_reg <= sel_reg + digit_sel_t'(1);
                if (sel_reg == LAST_DIGIT) begin
                    frame_start_reg <= 1'b1;
                    if (pending_reg) begin
                        disp_reg    <= shadow_data;
                        en_reg      <= shadow_mask;
                        pending_reg <= 1'b0;
                    end
                end
            end
            // NOTE: this write comes after the frame swap on purpose; when both
            // fire on one edge the later assignment wins and pending stays set.
            if (wr_en) begin
                shadow_data <= wr_data;
                shadow_mask <= wr_mask;
                pending_reg <= 1'b1;
            end
        end
    end

    // Outputs are muxed from registers only, so num/sel/blank move together.
    assign sel         = sel_reg;
    assign num         = digit_of(disp_reg, sel_reg);
    assign blank       = ~en_reg[sel_reg];
    assign pending     = pending_reg;
    assign frame_start = frame_start_reg;

endmodule
